// File: rtl/aes_decrypt_ctrl_if.sv
// Bus bundle of the iterative AES-128 decryption sequencer: block handshake,
// round-key store lookup and the round-datapath connections.
interface aes_decrypt_ctrl_if #(
  parameter int DW = 128,
  parameter int AW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          key_valid;
  logic [AW-1:0] rk_addr;
  logic [DW-1:0] rk_data;
  logic [DW-1:0] round_in;
  logic [DW-1:0] round_key;
  logic [DW-1:0] round_out;
  logic [DW-1:0] final_out;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          key_err;

  // master: the sequencer; slave: key store, datapaths and block producer/consumer
  modport master (
    input  in_valid, in_data, key_valid, rk_data, round_out, final_out, out_ready,
    output in_ready, rk_addr, round_in, round_key, out_valid, out_data, busy, key_err
  );

  modport slave (
    output in_valid, in_data, key_valid, rk_data, round_out, final_out, out_ready,
    input  in_ready, rk_addr, round_in, round_key, out_valid, out_data, busy, key_err
  );
endinterface

// File: rtl/aes_decrypt_ctrl.sv
// Iterative AES-128 decryption sequencer: initial AddRoundKey, NR-1 middle rounds
// through an external DecryptRound datapath, then one final-round pass.
module aes_decrypt_ctrl #(
  parameter int DW = 128,
  parameter int NR = 10,
  parameter int AW = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  aes_decrypt_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} ctrlState_t;

  localparam logic [AW-1:0] LastKeyIdx  = AW'(NR);
  localparam logic [AW-1:0] FirstMidIdx = AW'(NR - 1);
  localparam logic [AW-1:0] LastMidIdx  = AW'(1);

  ctrlState_t    stateQ, stateD;
  logic [DW-1:0] blockQ;
  logic [AW-1:0] cntQ;
  logic          keyErrQ;
  logic          accept;

  assign accept = (stateQ == IDLE) && bus.in_valid && bus.key_valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stateQ <= IDLE;
    else        stateQ <= stateD;
  end

  // NOTE: stateD gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE:    if (accept) stateD = ROUND;
      ROUND:   if (cntQ == LastMidIdx) stateD = FINAL;
      FINAL:   stateD = DONE;
      DONE:    if (bus.out_ready) stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.rk_addr   = LastKeyIdx;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.busy      = 1'b1;
    case (stateQ)
      IDLE: begin
        bus.in_ready = bus.key_valid;
        bus.busy     = 1'b0;
      end
      ROUND:   bus.rk_addr = cntQ;
      FINAL:   bus.rk_addr = '0;
      DONE: begin
        bus.out_valid = 1'b1;
        bus.out_data  = blockQ;
      end
      default: bus.busy = 1'b0;
    endcase
  end

  // Both datapaths always see the current block and key; the state only
  // decides which result, if any, is captured.
  assign bus.round_in  = blockQ;
  assign bus.round_key = bus.rk_data;
  assign bus.key_err   = keyErrQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blockQ  <= '0;
      cntQ    <= '0;
      keyErrQ <= 1'b0;
    end else begin
      case (stateQ)
        IDLE: begin
          if (accept) begin
            blockQ  <= bus.in_data ^ bus.rk_data;
            cntQ    <= FirstMidIdx;
            keyErrQ <= 1'b0;
          end
        end
        ROUND: begin
          blockQ <= bus.round_out;
          if (cntQ != LastMidIdx) cntQ <= cntQ - 1'b1;
          if (!bus.key_valid) keyErrQ <= 1'b1;
        end
        FINAL: begin
          blockQ <= bus.final_out;
          if (!bus.key_valid) keyErrQ <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt_ctrl.sv
// Directed bench for aes_decrypt_ctrl with a behavioural AES key store and
// inverse-round datapaths; checks FIPS-197 vectors, timing and handshakes.
module tb_aes_decrypt_ctrl;

  localparam logic [127:0] Key1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] Ct1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] Pt1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] Key2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] Ct2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] Pt2  = 128'h3243f6a8885a308d313198a2e0370734;

  logic clk = 1'b0;
  logic rst_n;
  int   nPass = 0;
  int   nChecks = 0;
  logic [127:0] rkStore [0:15];

  aes_decrypt_ctrl_if #(.DW(128), .AW(4)) bus ();

  aes_decrypt_ctrl #(.DW(128), .NR(10), .AW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- GF(2^8) and AES reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] res  = 8'h01;
    logic [7:0] base = x;
    logic [7:0] e    = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) res = gmul(res, base);
      base = gmul(base, base);
    end
    return res;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b = ginv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] invSbox(input logic [7:0] y);
    return ginv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
  endfunction

  // Byte k of the state is v[127-8k -: 8]; row r, column c is byte r+4c.
  function automatic logic [127:0] invShiftSub(input logic [127:0] v);
    logic [127:0] o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(r + 4*((c + r) % 4)) -: 8] = invSbox(v[127 - 8*(r + 4*c) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] invMix(input logic [127:0] v);
    logic [127:0] o = '0;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = v[127 - 8*(4*c)     -: 8];
      a1 = v[127 - 8*(4*c + 1) -: 8];
      a2 = v[127 - 8*(4*c + 2) -: 8];
      a3 = v[127 - 8*(4*c + 3) -: 8];
      o[127 - 8*(4*c)     -: 8] = gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09);
      o[127 - 8*(4*c + 1) -: 8] = gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d);
      o[127 - 8*(4*c + 2) -: 8] = gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b);
      o[127 - 8*(4*c + 3) -: 8] = gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e);
    end
    return o;
  endfunction

  task automatic load_keys(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rkStore[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  assign bus.rk_data = rkStore[bus.rk_addr];
  always_comb bus.round_out = invMix(invShiftSub(bus.round_in) ^ bus.round_key);
  always_comb bus.final_out = invShiftSub(bus.round_in) ^ bus.round_key;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One full operation. dropCycle>0 pulls key_valid low in that cycle;
  // rstCycle>0 pulses reset in that cycle and abandons the block.
  // Cycle 0 is the accept cycle; cycle c is sampled at its falling edge.
  task automatic run_op(input string tag, input logic [127:0] ct, input logic [127:0] pt,
                        input int dropCycle, input int rstCycle, input int holdCycles);
    int   waits = 0;
    int   lat = 0;
    logic seen = 1'b0;
    logic [3:0] expAddr;
    @(posedge clk); #1;
    bus.key_valid = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = ct;
    while (!seen && waits < 16) begin
      @(negedge clk);
      waits++;
      seen = bus.in_ready;
    end
    check({tag, ".accept_wait"}, 128'(waits), 128'd1);
    check({tag, ".addr0"}, 128'(bus.rk_addr), 128'd10);
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(posedge clk); #1;
      bus.in_valid  = 1'b0;
      bus.in_data   = ~ct;
      bus.key_valid = (c != dropCycle);
      if (c == rstCycle) begin
        rst_n = 1'b0;
        #1;
        check({tag, ".rst_busy"},     128'(bus.busy),      128'd0);
        check({tag, ".rst_out_valid"}, 128'(bus.out_valid), 128'd0);
        check({tag, ".rst_out_data"},  bus.out_data,        128'd0);
        check({tag, ".rst_key_err"},   128'(bus.key_err),   128'd0);
        check({tag, ".rst_addr"},      128'(bus.rk_addr),   128'd10);
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      @(negedge clk);
      if (c <= 11) begin
        expAddr = (c <= 9) ? 4'(10 - c) : (c == 10) ? 4'd0 : 4'd10;
        check($sformatf("%s.addr%0d", tag, c), 128'(bus.rk_addr), 128'(expAddr));
      end
      if (bus.out_valid) lat = c;
    end
    check({tag, ".latency"}, 128'(lat), 128'd11);
    if (lat == 0) return;
    check({tag, ".out_data"}, bus.out_data, pt);
    check({tag, ".key_err"},  128'(bus.key_err), 128'(dropCycle > 0));
    check({tag, ".busy"},     128'(bus.busy), 128'd1);
    check({tag, ".in_ready_done"}, 128'(bus.in_ready), 128'd0);
    for (int h = 1; h <= holdCycles; h++) begin
      @(negedge clk);
      check($sformatf("%s.hold%0d_valid", tag, h), 128'(bus.out_valid), 128'd1);
      check($sformatf("%s.hold%0d_data", tag, h),  bus.out_data, pt);
      check($sformatf("%s.hold%0d_ready", tag, h), 128'(bus.in_ready), 128'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check({tag, ".idle_valid"}, 128'(bus.out_valid), 128'd0);
    check({tag, ".idle_busy"},  128'(bus.busy), 128'd0);
    check({tag, ".idle_ready"}, 128'(bus.in_ready), 128'd1);
    check({tag, ".idle_addr"},  128'(bus.rk_addr), 128'd10);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.key_valid = 1'b0;
    bus.out_ready = 1'b0;
    load_keys(Key1);
    repeat (2) @(negedge clk);
    check("reset.out_valid", 128'(bus.out_valid), 128'd0);
    check("reset.out_data",  bus.out_data,        128'd0);
    check("reset.busy",      128'(bus.busy),      128'd0);
    check("reset.key_err",   128'(bus.key_err),   128'd0);
    check("reset.in_ready",  128'(bus.in_ready),  128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle.in_ready_nokey", 128'(bus.in_ready), 128'd0);
    check("idle.addr",           128'(bus.rk_addr),  128'd10);

    // Block offered while the key store is not ready: must not be taken.
    bus.in_valid = 1'b1;
    bus.in_data  = 128'hdeadbeef_00000000_ffffffff_12345678;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check($sformatf("nokey%0d.in_ready", i), 128'(bus.in_ready), 128'd0);
      check($sformatf("nokey%0d.busy", i),     128'(bus.busy),     128'd0);
    end

    run_op("fips_c1", Ct1, Pt1, 0, 0, 5);
    run_op("reset_mid", Ct1, Pt1, 0, 5, 0);
    run_op("after_reset", Ct1, Pt1, 0, 0, 0);
    run_op("key_drop", Ct1, Pt1, 7, 0, 0);
    run_op("clean", Ct1, Pt1, 0, 0, 1);

    load_keys(Key2);
    run_op("fips_b", Ct2, Pt2, 0, 0, 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
